btn_event_decoder: RTL and testbench

//  - Consumes debounced button levels and the shared 1 kHz enable tick from the CmodS7 button stage.
//  - Converts each button level into single-cycle event pulses: press, release, long-press and auto-repeat.
//  - These pulses drive the receiver UI control logic (gain/mode stepping). No level logic downstream.

---
 rtl/btn_event_decoder.sv | 149 ++++++++++++++
 tb/tb_btn_event_decoder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_decoder.sv
// btn_event_decoder: turns debounced button levels into single-cycle press/release/long/repeat pulses.
// Optional auto-repeat while long-held is compiled in when BTN_EVENT_REPEAT_EN is defined.
module btn_event_decoder #(
  parameter int DW            = 2,
  parameter int LONG_PRESS_MS = 1000,
  parameter int REPEAT_MS     = 200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic [DW-1:0] btn_i,
  output logic [DW-1:0] press_o,
  output logic [DW-1:0] release_o,
  output logic [DW-1:0] long_o,
  output logic [DW-1:0] repeat_o,
  output logic [DW-1:0] held_o
);

  localparam int MAX_MS = (LONG_PRESS_MS > REPEAT_MS) ? LONG_PRESS_MS : REPEAT_MS;
  localparam int CW     = $clog2(MAX_MS + 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_MS - 1);
`ifdef BTN_EVENT_REPEAT_EN
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_MS - 1);
`endif

  if (LONG_PRESS_MS < 1) begin : g_bad_long
    $error("btn_event_decoder: LONG_PRESS_MS must be >= 1");
  end
  if (REPEAT_MS < 1) begin : g_bad_repeat
    $error("btn_event_decoder: REPEAT_MS must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_t;

  for (genvar g = 0; g < DW; g++) begin : g_lane
    state_t        state, state_next;
    logic          prev, rise, fall;
    logic [CW-1:0] cnt, cnt_next;
    logic          press_d, release_d, long_d;
    logic          press_q, release_q, long_q, held_q;
`ifdef BTN_EVENT_REPEAT_EN
    logic          repeat_d, repeat_q;
`endif

    assign rise = btn_i[g] & ~prev;
    assign fall = ~btn_i[g] & prev;

    always_ff @(posedge clk) begin
      if (!rst) begin
        state     <= IDLE;
        prev      <= 1'b0;
        cnt       <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        held_q    <= 1'b0;
`ifdef BTN_EVENT_REPEAT_EN
        repeat_q  <= 1'b0;
`endif
      end else begin
        state     <= state_next;
        prev      <= btn_i[g];
        cnt       <= cnt_next;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
        held_q    <= (state_next != IDLE);
`ifdef BTN_EVENT_REPEAT_EN
        repeat_q  <= repeat_d;
`endif
      end
    end

    // A fall always takes priority over a tick that would hit a threshold.
    always_comb begin
      state_next = state;
      cnt_next   = cnt;
      press_d    = 1'b0;
      release_d  = 1'b0;
      long_d     = 1'b0;
`ifdef BTN_EVENT_REPEAT_EN
      repeat_d   = 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rise) begin
            state_next = PRESS;
            cnt_next   = '0;
            press_d    = 1'b1;
          end
        end
        PRESS: begin
          if (fall) begin
            state_next = IDLE;
            cnt_next   = '0;
            release_d  = 1'b1;
          end else if (en_i) begin
            if (cnt == LONG_LAST) begin
              state_next = LONG;
              cnt_next   = '0;
              long_d     = 1'b1;
            end else begin
              cnt_next = cnt + CW'(1);
            end
          end
        end
        LONG: begin
          if (fall) begin
            state_next = IDLE;
            cnt_next   = '0;
            release_d  = 1'b1;
          end else begin
`ifdef BTN_EVENT_REPEAT_EN
            if (en_i) begin
              if (cnt == REPEAT_LAST) begin
                cnt_next = '0;
                repeat_d = 1'b1;
              end else begin
                cnt_next = cnt + CW'(1);
              end
            end
`else
            cnt_next = '0;
`endif
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end

    assign press_o[g]   = press_q;
    assign release_o[g] = release_q;
    assign long_o[g]    = long_q;
    assign held_o[g]    = held_q;
`ifdef BTN_EVENT_REPEAT_EN
    assign repeat_o[g]  = repeat_q;
`else
    assign repeat_o[g]  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_btn_event_decoder.sv
// tb_btn_event_decoder: scenario and randomized checks of btn_event_decoder against a tick-counting model.
// Honours BTN_EVENT_REPEAT_EN so the same bench covers both builds.
module tb_btn_event_decoder;
  localparam int DW = 2;
  localparam int LP = 5;
  localparam int RP = 3;
`ifdef BTN_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en_i = 1'b0;
  logic [DW-1:0] btn_i = '0;
  logic [DW-1:0] press_o, release_o, long_o, repeat_o, held_o;

  btn_event_decoder #(.DW(DW), .LONG_PRESS_MS(LP), .REPEAT_MS(RP)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .btn_i(btn_i),
    .press_o(press_o), .release_o(release_o), .long_o(long_o),
    .repeat_o(repeat_o), .held_o(held_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: a lane is either held or not, and counts en ticks since its press.
  bit            m_held [DW];
  bit            m_prev [DW];
  int            m_ticks[DW];
  logic [DW-1:0] e_press = '0, e_release = '0, e_long = '0, e_repeat = '0, e_held = '0;
  logic [5*DW-1:0] got, exp_v;
  assign got   = {press_o, release_o, long_o, repeat_o, held_o};
  assign exp_v = {e_press, e_release, e_long, e_repeat, e_held};

  function automatic void model_update();
    bit rise, fall;
    e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
    for (int i = 0; i < DW; i++) begin
      if (!rst) begin
        m_held[i] = 0; m_prev[i] = 0; m_ticks[i] = 0;
      end else begin
        rise = btn_i[i] && !m_prev[i];
        fall = !btn_i[i] && m_prev[i];
        m_prev[i] = btn_i[i];
        if (!m_held[i]) begin
          if (rise) begin m_held[i] = 1; m_ticks[i] = 0; e_press[i] = 1'b1; end
        end else if (fall) begin
          m_held[i] = 0; e_release[i] = 1'b1;
        end else if (en_i) begin
          m_ticks[i]++;
          if (m_ticks[i] == LP) e_long[i] = 1'b1;
          else if (REP_EN && m_ticks[i] > LP && (m_ticks[i] - LP) % RP == 0) e_repeat[i] = 1'b1;
        end
      end
      e_held[i] = m_held[i];
    end
  endfunction

  // en_i is high on one clock in four; inputs change at negedge, outputs are read 1 ns after posedge.
  task automatic applyStimulus(input logic [DW-1:0] btn, input logic r);
    @(negedge clk);
    btn_i = btn;
    rst   = r;
    en_i  = (cyc % 4 == 3);
    cyc++;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, 1'b1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b01, 1'b0);
      checks++;
      if (got !== 10'b0) begin errors++; $display("[TB] FAIL reset_hold got %b exp %b", got, 10'b0); end
    end
    applyStimulus(2'b01, 1'b1);
    checks++;
    if (got !== exp_v) begin errors++; $display("[TB] FAIL reset_release got %b exp %b", got, exp_v); end
    checks++;
    if (press_o !== 2'b01 || held_o !== 2'b01) begin
      errors++; $display("[TB] FAIL reset_press press %b held %b exp 01 01", press_o, held_o);
    end
    applyStimulus(2'b01, 1'b1);
    checks++;
    if (got !== exp_v || press_o !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_pulse_width got %b exp %b", got, exp_v);
    end
    applyStimulus(2'b00, 1'b1);
    settle(4);
  endtask

  task automatic test_short_press();
    int ticks = 0, n_press = 0, n_rel = 0, n_long = 0;
    settle(3);
    for (int s = 0; s < 100; s++) begin
      logic [DW-1:0] b;
      b = (ticks < 3 || s == 0) ? 2'b01 : 2'b00;
      applyStimulus(b, 1'b1);
      if (s > 0 && b[0] && en_i) ticks++;
      checks++;
      if (got !== exp_v) begin errors++; $display("[TB] FAIL short_press step %0d got %b exp %b", s, got, exp_v); end
      n_press += int'(press_o[0]);
      n_rel   += int'(release_o[0]);
      n_long  += int'(long_o[0]);
      if (!b[0]) begin
        checks++;
        if (release_o[0] !== 1'b1 || held_o[0] !== 1'b0) begin
          errors++; $display("[TB] FAIL short_release release %b held %b exp 1 0", release_o[0], held_o[0]);
        end
        break;
      end
    end
    settle(4);
    checks++;
    if (n_press != 1 || n_rel != 1 || n_long != 0) begin
      errors++; $display("[TB] FAIL short_counts press %0d rel %0d long %0d exp 1 1 0", n_press, n_rel, n_long);
    end
  endtask

  task automatic test_long_hold();
    int ticks = 0, n_long = 0, n_rep = 0, long_tick = -1;
    logic [15:0] rep_mask = '0;
    logic [15:0] exp_mask;
    exp_mask = REP_EN ? 16'h0900 : 16'h0000;
    settle(3);
    applyStimulus(2'b10, 1'b1);
    checks++;
    if (got !== exp_v) begin errors++; $display("[TB] FAIL long_press got %b exp %b", got, exp_v); end
    for (int s = 0; s < 200 && ticks < 12; s++) begin
      applyStimulus(2'b10, 1'b1);
      if (en_i) ticks++;
      checks++;
      if (got !== exp_v) begin errors++; $display("[TB] FAIL long_hold tick %0d got %b exp %b", ticks, got, exp_v); end
      if (long_o[1]) begin n_long++; long_tick = ticks; end
      if (repeat_o[1]) begin n_rep++; if (ticks < 16) rep_mask[ticks] = 1'b1; end
    end
    applyStimulus(2'b00, 1'b1);
    checks++;
    if (got !== exp_v || release_o !== 2'b10) begin
      errors++; $display("[TB] FAIL long_release got %b exp %b", got, exp_v);
    end
    checks++;
    if (n_long != 1 || long_tick != LP) begin
      errors++; $display("[TB] FAIL long_timing count %0d tick %0d exp 1 %0d", n_long, long_tick, LP);
    end
    checks++;
    if (rep_mask !== exp_mask) begin
      errors++; $display("[TB] FAIL repeat_ticks got %h exp %h (count %0d)", rep_mask, exp_mask, n_rep);
    end
    settle(3);
  endtask

  task automatic test_fall_on_threshold();
    int ticks = 0, n_long = 0;
    bit done = 0;
    settle(3);
    applyStimulus(2'b01, 1'b1);
    for (int s = 0; s < 100 && !done; s++) begin
      logic [DW-1:0] b;
      b = (ticks == LP - 1 && cyc % 4 == 3) ? 2'b00 : 2'b01;
      applyStimulus(b, 1'b1);
      if (b[0] && en_i) ticks++;
      checks++;
      if (got !== exp_v) begin errors++; $display("[TB] FAIL fall_tick step %0d got %b exp %b", s, got, exp_v); end
      n_long += int'(long_o[0]);
      if (!b[0]) begin
        done = 1;
        checks++;
        if (en_i !== 1'b1 || release_o[0] !== 1'b1 || long_o[0] !== 1'b0 || held_o[0] !== 1'b0) begin
          errors++; $display("[TB] FAIL fall_wins en %b rel %b long %b held %b exp 1 1 0 0",
                             en_i, release_o[0], long_o[0], held_o[0]);
        end
      end
    end
    for (int s = 0; s < 8; s++) begin
      applyStimulus(2'b00, 1'b1);
      n_long += int'(long_o[0]);
      checks++;
      if (got !== exp_v) begin errors++; $display("[TB] FAIL fall_idle got %b exp %b", got, exp_v); end
    end
    checks++;
    if (!done || n_long != 0) begin
      errors++; $display("[TB] FAIL fall_summary done %0d long %0d exp 1 0", done, n_long);
    end
  endtask

  task automatic test_both_lanes();
    int h0, h1;
    h0 = $urandom_range(30, 70);
    h1 = h0 + $urandom_range(5, 40);
    settle(3);
    for (int s = 0; s < h1 + 6; s++) begin
      logic [DW-1:0] b;
      b[0] = (s < h0);
      b[1] = (s >= 2 && s < h1);
      applyStimulus(b, 1'b1);
      checks++;
      if (got !== exp_v) begin errors++; $display("[TB] FAIL both_lanes step %0d got %b exp %b", s, got, exp_v); end
    end
  endtask

  task automatic test_reset_mid_long();
    int ticks = 0, long_tick = -1;
    bit seen = 0;
    settle(3);
    applyStimulus(2'b01, 1'b1);
    for (int s = 0; s < 100 && !seen; s++) begin
      applyStimulus(2'b01, 1'b1);
      seen = long_o[0];
    end
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL mid_long_reach long %b exp 1", long_o[0]); end
    applyStimulus(2'b01, 1'b1);
    applyStimulus(2'b01, 1'b0);
    checks++;
    if (got !== 10'b0 || got !== exp_v) begin
      errors++; $display("[TB] FAIL mid_long_reset got %b exp %b", got, 10'b0);
    end
    applyStimulus(2'b01, 1'b1);
    checks++;
    if (press_o !== 2'b01 || got !== exp_v) begin
      errors++; $display("[TB] FAIL mid_long_repress got %b exp %b", got, exp_v);
    end
    for (int s = 0; s < 100 && long_tick < 0; s++) begin
      applyStimulus(2'b01, 1'b1);
      if (en_i) ticks++;
      checks++;
      if (got !== exp_v) begin errors++; $display("[TB] FAIL mid_long_restart got %b exp %b", got, exp_v); end
      if (long_o[0]) long_tick = ticks;
    end
    checks++;
    if (long_tick != LP) begin
      errors++; $display("[TB] FAIL mid_long_timer tick %0d exp %0d", long_tick, LP);
    end
    settle(3);
  endtask

  task automatic test_random();
    logic [DW-1:0] b = '0;
    int remain[DW];
    for (int i = 0; i < DW; i++) remain[i] = $urandom_range(1, 40);
    for (int s = 0; s < 1200; s++) begin
      logic r;
      for (int i = 0; i < DW; i++) begin
        if (--remain[i] <= 0) begin
          b[i] = ~b[i];
          remain[i] = $urandom_range(1, 50);
        end
      end
      r = ($urandom_range(0, 199) != 0);
      applyStimulus(b, r);
      checks++;
      if (got !== exp_v) begin errors++; $display("[TB] FAIL random step %0d got %b exp %b", s, got, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_hold();
    test_fall_on_threshold();
    test_both_lanes();
    test_reset_mid_long();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
